imem_decomp: RTL and testbench

Dictionary-based instruction-memory decompressor sitting directly downstream of the instruction cache's refill port. It serves the cache's one-word-at-a-time refill reads by fetching 16-bit codewords from backing memory and expanding each into a 32-bit instruction, either from an on-block dictionary or from an escape (raw) word store. Addresses outside the compressed text region pass through unmodified. After reset, the block loads its dictionary from backing memory before accepting any request.

---
 rtl/imem_decomp_pkg.sv | 30 +++
 rtl/imem_decomp_dict.sv | 27 ++
 rtl/imem_decomp.sv | 199 +++++++++++++++++++
 tb/tb_imem_decomp.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_decomp_pkg.sv
// Shared types, codeword field layout and address helpers for the
// instruction-memory decompressor.
package imem_decomp_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CODE,
    ST_RAW,
    ST_PASS,
    ST_RESP
  } state_t;

  localparam int CW_ESC_BIT   = 15;
  localparam int CW_RAW_IDX_W = 15;

  // Word address of the 32-bit word holding the codeword for text offset
  // 'offset' (byte offset from the text base); codewords are 16 bits each.
  function automatic logic [31:0] code_word_addr(input logic [31:0] offset,
                                                 input logic [31:0] code_base);
    return (code_base + 32'({offset[31:2], 1'b0})) & ~32'h3;
  endfunction

  // Word address of an escape entry in the raw word store.
  function automatic logic [31:0] raw_word_addr(input logic [CW_RAW_IDX_W-1:0] idx,
                                                input logic [31:0] raw_base);
    return raw_base + {15'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_decomp_dict.sv
// Dictionary storage: one synchronous write port used while loading,
// one asynchronous read port used during codeword expansion.
module imem_decomp_dict
  import imem_decomp_pkg::*;
#(
  parameter int DICT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [DICT_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [DICT_BITS-1:0] raddr,
  output logic [31:0]          rdata
);

  logic [31:0] entries [2**DICT_BITS];

  // No reset: contents are undefined until the load sequence has run.
  always_ff @(posedge clk) begin
    if (we) begin
      entries[waddr] <= wdata;
    end
  end

  assign rdata = entries[raddr];

endmodule

// File: rtl/imem_decomp.sv
// Dictionary-based instruction fetch decompressor between the I-cache refill
// port and backing memory. Optional code word buffer: IMEM_DECOMP_CODE_BUF_EN.
module imem_decomp
  import imem_decomp_pkg::*;
#(
  parameter int          DICT_BITS  = 8,
  parameter logic [31:0] TEXT_BASE  = 32'h0000_0000,
  parameter int          TEXT_WORDS = 4096,
  parameter logic [31:0] CODE_BASE  = 32'h0001_0000,
  parameter logic [31:0] RAW_BASE   = 32'h0002_0000,
  parameter logic [31:0] DICT_BASE  = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_rdata,
  output logic        bmem_valid,
  input  logic        bmem_ready,
  output logic [31:0] bmem_addr,
  input  logic [31:0] bmem_rdata
);

  localparam logic [31:0] TEXT_BYTES = 32'(TEXT_WORDS) << 2;
  localparam logic [DICT_BITS-1:0] IDX_LAST = '1;

  state_t               state;
  logic                 bmem_valid_reg;
  logic [31:0]          bmem_addr_reg;
  logic [31:0]          rdata_reg;
  logic [DICT_BITS-1:0] init_idx;
  logic                 half_reg;
  logic                 gap_reg;

  logic [31:0]          req_off;
  logic                 req_in_text;
  logic [31:0]          req_code_addr;
  logic [31:0]          cw_word;
  logic                 cw_hi;
  logic [15:0]          cw;
  logic [31:0]          dict_rdata;
  logic                 dict_we;

  // Unsigned offset makes addresses below TEXT_BASE wrap to huge values.
  assign req_off       = mem_req_addr - TEXT_BASE;
  assign req_in_text   = (req_off < TEXT_BYTES);
  assign req_code_addr = code_word_addr(req_off, CODE_BASE);

`ifdef IMEM_DECOMP_CODE_BUF_EN
  logic        buf_valid;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;
  logic        buf_hit;

  assign buf_hit = buf_valid && (buf_addr == req_code_addr);
  // In IDLE the codeword comes from the buffer, otherwise from the fetch.
  assign cw_word = (state == ST_IDLE) ? buf_data : bmem_rdata;
  assign cw_hi   = (state == ST_IDLE) ? req_off[2] : half_reg;
`else
  assign cw_word = bmem_rdata;
  assign cw_hi   = half_reg;
`endif

  assign cw      = cw_hi ? cw_word[31:16] : cw_word[15:0];
  assign dict_we = (state == ST_INIT) && bmem_valid_reg && bmem_ready;

  imem_decomp_dict #(
    .DICT_BITS(DICT_BITS)
  ) u_dict (
    .clk  (clk),
    .we   (dict_we),
    .waddr(init_idx),
    .wdata(bmem_rdata),
    .raddr(cw[DICT_BITS-1:0]),
    .rdata(dict_rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_INIT;
      bmem_valid_reg <= 1'b0;
      bmem_addr_reg  <= 32'h0;
      rdata_reg      <= 32'h0;
      init_idx       <= '0;
      half_reg       <= 1'b0;
      gap_reg        <= 1'b0;
`ifdef IMEM_DECOMP_CODE_BUF_EN
      buf_valid      <= 1'b0;
      buf_addr       <= 32'h0;
      buf_data       <= 32'h0;
`endif
    end else begin
      case (state)
        ST_INIT: begin
          if (!bmem_valid_reg) begin
            bmem_valid_reg <= 1'b1;
            bmem_addr_reg  <= DICT_BASE + 32'({init_idx, 2'b00});
          end else if (bmem_ready) begin
            bmem_valid_reg <= 1'b0;
            init_idx       <= init_idx + 1'b1;
            if (init_idx == IDX_LAST) begin
              state <= ST_IDLE;
            end
          end
        end

        ST_IDLE: begin
          // gap_reg masks the first IDLE cycle after a response.
          gap_reg <= 1'b0;
          if (!gap_reg && mem_req_valid) begin
            if (req_in_text) begin
              half_reg <= req_off[2];
`ifdef IMEM_DECOMP_CODE_BUF_EN
              if (buf_hit) begin
                if (cw[CW_ESC_BIT]) begin
                  rdata_reg <= dict_rdata;
                  state     <= ST_RESP;
                end else begin
                  bmem_valid_reg <= 1'b1;
                  bmem_addr_reg  <= raw_word_addr(cw[CW_RAW_IDX_W-1:0], RAW_BASE);
                  state          <= ST_RAW;
                end
              end else begin
                bmem_valid_reg <= 1'b1;
                bmem_addr_reg  <= req_code_addr;
                state          <= ST_CODE;
              end
`else
              bmem_valid_reg <= 1'b1;
              bmem_addr_reg  <= req_code_addr;
              state          <= ST_CODE;
`endif
            end else begin
              bmem_valid_reg <= 1'b1;
              bmem_addr_reg  <= {mem_req_addr[31:2], 2'b00};
              state          <= ST_PASS;
            end
          end
        end

        ST_CODE: begin
          if (bmem_valid_reg && bmem_ready) begin
            bmem_valid_reg <= 1'b0;
`ifdef IMEM_DECOMP_CODE_BUF_EN
            buf_valid <= 1'b1;
            buf_addr  <= bmem_addr_reg;
            buf_data  <= bmem_rdata;
`endif
            if (cw[CW_ESC_BIT]) begin
              rdata_reg <= dict_rdata;
              state     <= ST_RESP;
            end else begin
              bmem_addr_reg <= raw_word_addr(cw[CW_RAW_IDX_W-1:0], RAW_BASE);
              state         <= ST_RAW;
            end
          end
        end

        ST_RAW: begin
          // Entered with bmem_valid low after a code fetch, so the raw read
          // goes out one idle cycle later; entered with it high from a buffer hit.
          if (!bmem_valid_reg) begin
            bmem_valid_reg <= 1'b1;
          end else if (bmem_ready) begin
            bmem_valid_reg <= 1'b0;
            rdata_reg      <= bmem_rdata;
            state          <= ST_RESP;
          end
        end

        ST_PASS: begin
          if (bmem_valid_reg && bmem_ready) begin
            bmem_valid_reg <= 1'b0;
            rdata_reg      <= bmem_rdata;
            state          <= ST_RESP;
          end
        end

        ST_RESP: begin
          gap_reg <= 1'b1;
          state   <= ST_IDLE;
        end

        default: begin
          state          <= ST_INIT;
          bmem_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // A result nobody is waiting for is dropped rather than held.
  assign mem_req_ready = (state == ST_RESP) && mem_req_valid;
  assign mem_req_rdata = rdata_reg;
  assign bmem_valid    = bmem_valid_reg;
  assign bmem_addr     = bmem_addr_reg;

endmodule

// File: tb/tb_imem_decomp.sv
// Directed bench for imem_decomp with a spec-level expansion model and a
// 1-cycle-latency backing memory responder.
module tb_imem_decomp;

  localparam int          DB         = 2;
  localparam logic [31:0] TEXT_BASE  = 32'h0000_0000;
  localparam int          TEXT_WORDS = 4096;
  localparam logic [31:0] TEXT_BYTES = 32'h0000_4000;
  localparam logic [31:0] CODE_BASE  = 32'h0001_0000;
  localparam logic [31:0] RAW_BASE   = 32'h0002_0000;
  localparam logic [31:0] DICT_BASE  = 32'h0003_0000;
  localparam int          LAT        = 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_req_valid = 1'b0;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr = 32'h0;
  logic [31:0] mem_req_rdata;
  logic        bmem_valid;
  logic        bmem_ready = 1'b0;
  logic [31:0] bmem_addr;
  logic [31:0] bmem_rdata = 32'h0;

  imem_decomp #(
    .DICT_BITS (DB),
    .TEXT_BASE (TEXT_BASE),
    .TEXT_WORDS(TEXT_WORDS),
    .CODE_BASE (CODE_BASE),
    .RAW_BASE  (RAW_BASE),
    .DICT_BASE (DICT_BASE)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_req_rdata(mem_req_rdata),
    .bmem_valid   (bmem_valid),
    .bmem_ready   (bmem_ready),
    .bmem_addr    (bmem_addr),
    .bmem_rdata   (bmem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int ready_cnt = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] bmem_log [$];

`ifdef IMEM_DECOMP_CODE_BUF_EN
  bit          buf_v = 1'b0;
  logic [31:0] buf_a = 32'h0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [15:0] model_cw(input logic [31:0] a);
    logic [31:0] n;
    logic [31:0] w;
    n = (a - TEXT_BASE) >> 2;
    w = mem_rd((CODE_BASE + 2 * n) & ~32'h3);
    return n[0] ? w[31:16] : w[15:0];
  endfunction

  // What the cache must see for address a, straight from the mapping rules.
  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [15:0] c;
    if ((a - TEXT_BASE) < TEXT_BYTES) begin
      c = model_cw(a);
      if (c[15]) return mem_rd(DICT_BASE + 4 * 32'(c % (1 << DB)));
      return mem_rd(RAW_BASE + 4 * 32'(c[14:0]));
    end
    return mem_rd(a & ~32'h3);
  endfunction

  // Backing memory: answers each read LAT cycles after bmem_valid is seen.
  initial begin
    int wcnt;
    logic [31:0] txn_addr;
    wcnt = 0;
    txn_addr = 32'h0;
    forever begin
      @(posedge clk);
      #3;
      if (bmem_ready) begin
        bmem_ready = 1'b0;
        check("bmem_valid_drop", bmem_valid, 1'b0);
        continue;
      end
      if (resetn && bmem_valid) begin
        if (wcnt == 0) txn_addr = bmem_addr;
        if (wcnt >= LAT) begin
          check("bmem_addr_stable", bmem_addr, txn_addr);
          bmem_ready = 1'b1;
          bmem_rdata = mem_rd(bmem_addr);
          bmem_log.push_back(bmem_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Every response is checked against the model while it is on the port.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_ready === 1'b1) begin
        ready_cnt++;
        check("ready_needs_valid", mem_req_valid, 1'b1);
        check("rdata_model", mem_req_rdata, model_word(mem_req_addr));
      end
    end
  end

  task automatic run_req(input logic [31:0] a, input logic [31:0] exp_data,
                         input string name, input bit first, input bit drop);
    logic [31:0] q [$];
    logic [31:0] ca;
    logic [15:0] c;
    int k;
    int lat;
    int rc0;
    bit got;
    if (first) begin
      for (int i = 0; i < (1 << DB); i++) q.push_back(DICT_BASE + 32'(4 * i));
    end else begin
      bmem_log.delete();
    end
    if ((a - TEXT_BASE) < TEXT_BYTES) begin
      ca = (CODE_BASE + 2 * ((a - TEXT_BASE) >> 2)) & ~32'h3;
      c = model_cw(a);
`ifdef IMEM_DECOMP_CODE_BUF_EN
      if (!(buf_v && buf_a == ca)) q.push_back(ca);
      buf_v = 1'b1;
      buf_a = ca;
`else
      q.push_back(ca);
`endif
      if (!c[15]) q.push_back(RAW_BASE + {15'b0, c[14:0], 2'b00});
    end else begin
      q.push_back(a & ~32'h3);
    end
    rc0 = ready_cnt;
    @(posedge clk);
    #3;
    mem_req_addr = a;
    mem_req_valid = 1'b1;
    k = cyc;
    if (drop) begin
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(posedge clk);
        #1;
        if (bmem_log.size() == q.size() - 1 && bmem_valid) got = 1'b1;
      end
      check({name, "_raw_issued"}, 32'(got), 32'd1);
      #2;
      mem_req_valid = 1'b0;
      repeat (12) @(posedge clk);
      check({name, "_no_ready"}, ready_cnt, rc0);
    end else begin
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(posedge clk);
        #1;
        if (mem_req_ready === 1'b1) got = 1'b1;
      end
      lat = cyc - k;
      check({name, "_served"}, 32'(got), 32'd1);
      check({name, "_data"}, mem_req_rdata, exp_data);
      // With 1-cycle backing latency each read costs three cycles
      // (issue, response, idle/response); a buffered hit answers next cycle.
      if (!first) check({name, "_lat"}, lat, (q.size() == 0) ? 1 : 3 * q.size());
      #2;
      mem_req_valid = 1'b0;
      repeat (3) @(posedge clk);
    end
    check({name, "_nreads"}, bmem_log.size(), q.size());
    foreach (q[i]) begin
      if (i < bmem_log.size()) check($sformatf("%s_rd%0d", name, i), bmem_log[i], q[i]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) mem[DICT_BASE + 32'(4 * i)] = 32'hA0 + 32'(i);
    mem[32'h0001_0000] = 32'h8002_8001;
    mem[32'h0001_0004] = 32'h8003_0005;
    mem[32'h0001_0008] = 32'h0001_8006;
    mem[32'h0001_000C] = 32'h8001_0007;
    mem[32'h0001_1FFC] = 32'h8000_1234;
    mem[32'h0002_0014] = 32'hDEAD_BEEF;
    mem[32'h0002_0004] = 32'hCAFE_F00D;
    mem[32'h0002_001C] = 32'h7777_1111;
    mem[32'h1000_0000] = 32'h1234_5678;
    mem[32'h0000_4000] = 32'h0BAD_F00D;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", mem_req_ready, 1'b0);
    check("rst_rdata", mem_req_rdata, 32'h0);
    check("rst_bvalid", bmem_valid, 1'b0);
    check("rst_baddr", bmem_addr, 32'h0);
    #2;
    resetn = 1'b1;

    // Request held during the dictionary load.
    run_req(32'h0000_0004, 32'h0000_00A2, "init_hit", 1'b1, 1'b0);
    run_req(32'h0000_0008, 32'hDEAD_BEEF, "escape", 1'b0, 1'b0);
    check("escape_code_addr", bmem_log[0], 32'h0001_0004);
    check("escape_raw_addr", bmem_log[1], 32'h0002_0014);
    run_req(32'h0000_000C, 32'h0000_00A3, "hit_hi", 1'b0, 1'b0);
    run_req(32'h1000_0000, 32'h1234_5678, "pass", 1'b0, 1'b0);
    check("pass_addr", bmem_log[0], 32'h1000_0000);
    run_req(32'h1000_0003, 32'h1234_5678, "pass_lowbits", 1'b0, 1'b0);
    run_req(32'h0000_3FFC, 32'h0000_00A0, "last_word", 1'b0, 1'b0);
    run_req(32'h0000_4000, 32'h0BAD_F00D, "past_end", 1'b0, 1'b0);
    run_req(32'hFFFF_FFFC, 32'hA5A5_A5A6, "wrap", 1'b0, 1'b0);
    run_req(32'h0000_0010, 32'h0000_00A2, "idx_mask", 1'b0, 1'b0);
    run_req(32'h0000_0014, 32'hCAFE_F00D, "escape_hi", 1'b0, 1'b0);
    run_req(32'h0000_0018, 32'h7777_1111, "drop", 1'b0, 1'b1);
    run_req(32'h0000_001C, 32'h0000_00A1, "after_drop", 1'b0, 1'b0);
    run_req(32'h0000_0000, 32'h0000_00A1, "seq0", 1'b0, 1'b0);
    run_req(32'h0000_0004, 32'h0000_00A2, "seq1", 1'b0, 1'b0);
`ifdef IMEM_DECOMP_CODE_BUF_EN
    check("seq1_code_reads", bmem_log.size(), 0);
`else
    check("seq1_code_reads", bmem_log.size(), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
